karatsuba_split_dispatch_104bit: RTL and testbench
==================================================

Name: karatsuba_split_dispatch_104bit

Overview:
- Front end of the 104-bit Karatsuba GF(2) multiplier; the counterpart of the overlap/recombine stage.
- Accepts two 104-bit binary polynomials, splits each into 52-bit halves and issues three 52x52 sub-products (lo, hi, mid) to one shared sub-multiplier over a valid/ready interface.
- Collects the three 103-bit results, forms the corrected middle term, and presents the in1/in2/in3 triple to the overlap stage with a valid/ready handshake.

Parameters:
- N, 104, operand width in bits; must be even. H = N/2 is derived internally.
- RW, 2*(N/2)-1 = 103, sub-product and result width; derived, not overridable.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_a  in  N  operand A; bit i is the coefficient of x^i
- in_b  in  N  operand B
- mul_valid  out  1  sub-multiplier request valid
- mul_ready  in  1  sub-multiplier accepts request
- mul_a  out  H  sub-operand A
- mul_b  out  H  sub-operand B
- mul_tag  out  2  sub-product tag: 0=lo, 1=hi, 2=mid
- res_valid  in  1  sub-product result valid; results always return in issue order
- res_tag  in  2  tag of the returning result
- res_data  in  RW  sub-product result
- out_valid  out  1  recombine triple valid
- out_ready  in  1  overlap stage accepts the triple
- out_lo  out  RW  P_lo = A_lo*B_lo, drives overlap in1
- out_mid  out  RW  P_mid ^ P_lo ^ P_hi, drives overlap in2
- out_hi  out  RW  P_hi = A_hi*B_hi, drives overlap in3
- err  out  1  sticky error flag for a tag mismatch

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE and in_ready=1.
  - mul_valid, out_valid and err go to 0.
  - mul_a, mul_b, mul_tag, out_lo, out_mid and out_hi go to 0.
  - All counters clear.
  - An operation in flight is abandoned; results that arrive later are ignored until the next accept.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready:
    - latch A_lo=in_a[H-1:0], A_hi=in_a[N-1:H], and the same split for B;
    - compute A_m=A_lo^A_hi and B_m=B_lo^B_hi;
    - clear issue_cnt and res_cnt;
    - go to RUN and drop in_ready the next cycle.
- RUN, issue side:
  - mul_valid=1 while issue_cnt<3.
  - The sub-operands are chosen by issue_cnt: 0 gives (A_lo,B_lo) with tag 0, 1 gives (A_hi,B_hi) with tag 1, 2 gives (A_m,B_m) with tag 2.
  - mul_a, mul_b and mul_tag hold stable while mul_valid&!mul_ready.
  - issue_cnt increments on mul_valid&mul_ready.
  - mul_valid is 0 the cycle after the third accept.
- RUN, collect side:
  - On res_valid, res_data is stored into the slot selected by res_cnt, then res_cnt increments.
  - If res_tag!=res_cnt[1:0], err is set; the data is still stored by res_cnt.
  - res_valid arriving in the same cycle as an issue handshake is legal.
  - res_valid while not in RUN is ignored.
- RUN to DONE:
  - The move happens on the cycle res_cnt reaches 3.
  - In the same transition the block registers out_lo=P_lo, out_hi=P_hi and out_mid=P_mid^P_lo^P_hi.
  - out_valid=1 in the first DONE cycle.
- DONE:
  - out_* and out_valid hold while !out_ready.
  - On out_valid&out_ready: go to IDLE, out_valid=0 and in_ready=1 the next cycle.
- Throughput and latency:
  - One operation at a time.
  - Minimum latency from accept to out_valid is 3 + L + 1 cycles with L the sub-multiplier latency, mul_ready held at 1.
- err: cleared only by rst.

Optional Feature:
- KS_ZERO_BYPASS_EN.
- Defined:
  - on accept, if in_a==0 or in_b==0, the block skips RUN entirely;
  - no mul_valid is issued;
  - DONE is entered the next cycle with out_lo=out_mid=out_hi=0.
- Undefined: all operands go through RUN, including zero operands.

Test Plan:
- Unit product: in_a=1, in_b=1, mul_ready=1, results from a 1-cycle model → out_lo=1, out_mid=0, out_hi=0; exactly 3 mul handshakes with tags 0,1,2.
- High-half product: in_a=in_b=1<<52 → out_lo=0, out_mid=0, out_hi=1, so the overlap output is x^104.
- Mixed halves: in_a=(1<<52)|1, in_b=1 → mul sub-operands (1,1), (1,0), (0,1); out_lo=1, out_mid=1, out_hi=0.
- Backpressure and stall:
  - mul_ready low for 5 cycles with mul_a/mul_b/mul_tag held stable → no request lost;
  - out_ready low for 4 cycles → out_* held and in_ready=0 throughout;
  - next operand accepted only after the out handshake.
- Tag error and reset:
  - return res_tag=1 as the first result → err=1 and sticky;
  - assert rst mid-RUN → all outputs reset to 0 and in_ready=1 the next cycle;
  - late res_valid pulses after reset → ignored.
- Zero bypass with KS_ZERO_BYPASS_EN defined: in_a=0, in_b=0x5A → no mul_valid, and out_valid asserts with all-zero outputs 2 cycles after accept.

Source files
------------

// File: rtl/karatsuba_split_dispatch_104bit.sv
`default_nettype none
// ============================================================================
//  Module   : karatsuba_split_dispatch_104bit
//  Purpose  : Front end of the 104-bit Karatsuba GF(2) multiplier. Splits two
//             N-bit binary polynomials into halves, issues the lo/hi/mid
//             sub-products to a shared sub-multiplier, collects the results
//             in issue order and presents (P_lo, P_mid^P_lo^P_hi, P_hi) to
//             the overlap/recombine stage.
//  Options  : KS_ZERO_BYPASS_EN - a zero operand skips the sub-multiplier and
//             produces an all-zero triple directly.
//  Revision : 1.0 - initial release
// ============================================================================
module karatsuba_split_dispatch_104bit #(
  parameter int N = 104
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic             mul_valid,
  input  logic             mul_ready,
  output logic [N/2-1:0]   mul_a,
  output logic [N/2-1:0]   mul_b,
  output logic [1:0]       mul_tag,
  input  logic             res_valid,
  input  logic [1:0]       res_tag,
  input  logic [N-2:0]     res_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-2:0]     out_lo,
  output logic [N-2:0]     out_mid,
  output logic [N-2:0]     out_hi,
  output logic             err
);

  localparam int H  = N / 2;
  localparam int RW = 2 * H - 1;

  // S_ZERO is only reachable when the zero bypass is compiled in
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ZERO = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_in_ready;
  logic            r_mul_valid;
  logic [H-1:0]    r_mul_a;
  logic [H-1:0]    r_mul_b;
  logic [1:0]      r_mul_tag;
  logic [1:0]      r_issue_cnt;
  logic [1:0]      r_res_cnt;
  logic [H-1:0]    r_a_hi;
  logic [H-1:0]    r_b_hi;
  logic [H-1:0]    r_a_m;
  logic [H-1:0]    r_b_m;
  logic [RW-1:0]   r_p_lo;
  logic [RW-1:0]   r_p_hi;
  logic            r_out_valid;
  logic [RW-1:0]   r_out_lo;
  logic [RW-1:0]   r_out_mid;
  logic [RW-1:0]   r_out_hi;
  logic            r_err;

  logic [H-1:0]    w_a_lo;
  logic [H-1:0]    w_a_hi;
  logic [H-1:0]    w_b_lo;
  logic [H-1:0]    w_b_hi;
  logic            w_accept;
  logic            w_mul_fire;

  assign w_a_lo     = in_a[H-1:0];
  assign w_a_hi     = in_a[N-1:H];
  assign w_b_lo     = in_b[H-1:0];
  assign w_b_hi     = in_b[N-1:H];
  assign w_accept   = in_valid & r_in_ready;
  assign w_mul_fire = r_mul_valid & mul_ready;

`ifdef KS_ZERO_BYPASS_EN
  logic            w_zero_op;
  assign w_zero_op  = (in_a == '0) | (in_b == '0);
`endif

  // Control FSM: accept, issue three sub-products, collect in order, present triple
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_mul_valid <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_tag   <= 2'd0;
      r_issue_cnt <= 2'd0;
      r_res_cnt   <= 2'd0;
      r_a_hi      <= '0;
      r_b_hi      <= '0;
      r_a_m       <= '0;
      r_b_m       <= '0;
      r_p_lo      <= '0;
      r_p_hi      <= '0;
      r_out_valid <= 1'b0;
      r_out_lo    <= '0;
      r_out_mid   <= '0;
      r_out_hi    <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a_hi      <= w_a_hi;
            r_b_hi      <= w_b_hi;
            r_a_m       <= w_a_lo ^ w_a_hi;
            r_b_m       <= w_b_lo ^ w_b_hi;
            r_issue_cnt <= 2'd0;
            r_res_cnt   <= 2'd0;
            r_in_ready  <= 1'b0;
`ifdef KS_ZERO_BYPASS_EN
            if (w_zero_op) begin
              r_state <= S_ZERO;
            end else begin
              r_state     <= S_RUN;
              r_mul_valid <= 1'b1;
              r_mul_a     <= w_a_lo;
              r_mul_b     <= w_b_lo;
              r_mul_tag   <= 2'd0;
            end
`else
            r_state     <= S_RUN;
            r_mul_valid <= 1'b1;
            r_mul_a     <= w_a_lo;
            r_mul_b     <= w_b_lo;
            r_mul_tag   <= 2'd0;
`endif
          end
        end
        S_RUN: begin
          // Issue side: the lo request is preloaded at accept, hi and mid follow
          if (w_mul_fire) begin
            r_issue_cnt <= r_issue_cnt + 2'd1;
            case (r_issue_cnt)
              2'd0: begin
                r_mul_a   <= r_a_hi;
                r_mul_b   <= r_b_hi;
                r_mul_tag <= 2'd1;
              end
              2'd1: begin
                r_mul_a   <= r_a_m;
                r_mul_b   <= r_b_m;
                r_mul_tag <= 2'd2;
              end
              default: r_mul_valid <= 1'b0;
            endcase
          end
          // Collect side: slot chosen by arrival order, tag only cross-checked
          if (res_valid) begin
            if (res_tag != r_res_cnt) begin
              r_err <= 1'b1;
            end
            r_res_cnt <= r_res_cnt + 2'd1;
            case (r_res_cnt)
              2'd0: r_p_lo <= res_data;
              2'd1: r_p_hi <= res_data;
              default: begin
                r_out_lo    <= r_p_lo;
                r_out_hi    <= r_p_hi;
                r_out_mid   <= res_data ^ r_p_lo ^ r_p_hi;
                r_out_valid <= 1'b1;
                r_mul_valid <= 1'b0;
                r_state     <= S_DONE;
              end
            endcase
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
`ifdef KS_ZERO_BYPASS_EN
          r_out_lo    <= '0;
          r_out_mid   <= '0;
          r_out_hi    <= '0;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
`else
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
`endif
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mul_valid = r_mul_valid;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign mul_tag   = r_mul_tag;
  assign out_valid = r_out_valid;
  assign out_lo    = r_out_lo;
  assign out_mid   = r_out_mid;
  assign out_hi    = r_out_hi;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_karatsuba_split_dispatch_104bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_karatsuba_split_dispatch_104bit
//  Purpose  : Scoreboard bench for karatsuba_split_dispatch_104bit with a
//             behavioural sub-multiplier and an independent product model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_karatsuba_split_dispatch_104bit;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [103:0]   in_a;
  logic [103:0]   in_b;
  logic           mul_valid;
  logic           mul_ready;
  logic [51:0]    mul_a;
  logic [51:0]    mul_b;
  logic [1:0]     mul_tag;
  logic           res_valid;
  logic [1:0]     res_tag;
  logic [102:0]   res_data;
  logic           out_valid;
  logic           out_ready;
  logic [102:0]   out_lo;
  logic [102:0]   out_mid;
  logic [102:0]   out_hi;
  logic           err;

  karatsuba_split_dispatch_104bit #(.N(104)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_tag(mul_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lo(out_lo), .out_mid(out_mid), .out_hi(out_hi), .err(err)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [102:0] lo; logic [102:0] mid; logic [102:0] hi; int acc; int lat; } exp_t;
  typedef struct { logic [51:0] a; logic [51:0] b; logic [1:0] tag; } req_t;
  typedef struct { logic [102:0] d; logic [1:0] tag; int due; } pend_t;

  exp_t  q_out[$];
  req_t  q_mul[$];
  pend_t q_res[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mul_stall = 0;
  int out_hold  = 0;
  int last_due  = 0;
  bit rand_ready = 0, rand_lat = 0, rand_out = 0, corrupt_first = 0, out_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Carry-less polynomial product of two 52-bit polynomials
  function automatic logic [102:0] clmul(input logic [51:0] a, input logic [51:0] b);
    logic [102:0] p;
    p = '0;
    for (int i = 0; i < 52; i++)
      if (a[i]) p = p ^ ({51'd0, b} << i);
    return p;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // Expected results: lo/hi halves and the cross term of schoolbook multiplication
  task automatic push_expect(input logic [103:0] a, input logic [103:0] b, input int lat);
    exp_t e;
    req_t r;
    bit   issue;
    e.lo  = clmul(a[51:0], b[51:0]);
    e.hi  = clmul(a[103:52], b[103:52]);
    e.mid = clmul(a[51:0], b[103:52]) ^ clmul(a[103:52], b[51:0]);
    e.acc = cyc;
    e.lat = lat;
    q_out.push_back(e);
    issue = 1'b1;
`ifdef KS_ZERO_BYPASS_EN
    issue = (a != '0) && (b != '0);
`endif
    if (issue) begin
      r.a = a[51:0];   r.b = b[51:0];   r.tag = 2'd0; q_mul.push_back(r);
      r.a = a[103:52]; r.b = b[103:52]; r.tag = 2'd1; q_mul.push_back(r);
      r.a = a[51:0] ^ a[103:52]; r.b = b[51:0] ^ b[103:52]; r.tag = 2'd2; q_mul.push_back(r);
    end
  endtask

  task automatic do_op(input logic [103:0] a, input logic [103:0] b, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end else begin
      chk("accept_after_out", 128'(q_out.size()), 128'(0));
      push_expect(a, b, lat);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_out.size() != 0 || q_mul.size() != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (q_out.size() != 0 || q_mul.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: pending out=%0d mul=%0d required 0", q_out.size(), q_mul.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    q_out.delete();
    q_mul.delete();
    mul_stall = 0;
    out_hold = 0;
    out_seen = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_mul_valid", mul_valid, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk("rst_mul_a", 128'(mul_a), 128'(0));
    chk("rst_mul_b", 128'(mul_b), 128'(0));
    chk("rst_mul_tag", 128'(mul_tag), 128'(0));
    chk("rst_out_lo", 128'(out_lo), 128'(0));
    chk("rst_out_mid", 128'(out_mid), 128'(0));
    chk("rst_out_hi", 128'(out_hi), 128'(0));
  endtask

  // Sub-multiplier model: accepts requests, returns products in order after 1..3 cycles
  initial begin : mul_model
    logic        prev_stall;
    logic [51:0] pa, pb;
    logic [1:0]  pt;
    pend_t       pe;
    req_t        rq;
    int          lat_c, due;
    prev_stall = 1'b0;
    pa = '0; pb = '0; pt = '0;
    mul_ready = 1'b0; res_valid = 1'b0; res_tag = 2'd0; res_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        mul_ready  = 1'b0;
        res_valid  = 1'b0;
      end else begin
        if (prev_stall) begin
          chk1("mul_hold_valid", mul_valid, 1'b1);
          chk("mul_hold_a", 128'(mul_a), 128'(pa));
          chk("mul_hold_b", 128'(mul_b), 128'(pb));
          chk("mul_hold_tag", 128'(mul_tag), 128'(pt));
        end
        if (q_res.size() != 0 && q_res[0].due <= cyc) begin
          pe = q_res.pop_front();
          res_valid = 1'b1;
          res_data  = pe.d;
          res_tag   = pe.tag;
          if (corrupt_first) begin
            res_tag = (pe.tag == 2'd0) ? 2'd1 : 2'd0;
            corrupt_first = 1'b0;
          end
        end else begin
          res_valid = 1'b0;
          res_data  = {$urandom, $urandom, $urandom, $urandom};
          res_tag   = 2'($urandom_range(0, 3));
        end
        if (mul_stall > 0 && mul_valid) begin
          mul_ready = 1'b0;
          mul_stall--;
        end else if (rand_ready) begin
          mul_ready = ($urandom_range(0, 3) != 0);
        end else begin
          mul_ready = 1'b1;
        end
        if (mul_valid && mul_ready) begin
          if (q_mul.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL mul_unexpected: request tag=%0d a=%h, required none", mul_tag, mul_a);
          end else begin
            rq = q_mul.pop_front();
            chk("mul_req_a", 128'(mul_a), 128'(rq.a));
            chk("mul_req_b", 128'(mul_b), 128'(rq.b));
            chk("mul_req_tag", 128'(mul_tag), 128'(rq.tag));
          end
          lat_c = rand_lat ? int'($urandom_range(1, 3)) : 1;
          due = cyc + lat_c;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pe.d = clmul(mul_a, mul_b);
          pe.tag = mul_tag;
          pe.due = due;
          q_res.push_back(pe);
        end
        prev_stall = mul_valid && !mul_ready;
        pa = mul_a; pb = mul_b; pt = mul_tag;
      end
    end
  end

  // Output monitor: compares the presented triple against the scoreboard head
  initial begin : out_sink
    exp_t e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        out_ready = 1'b0;
      end else begin
        if (out_valid && out_hold > 0) begin
          out_ready = 1'b0;
          out_hold--;
        end else if (rand_out) begin
          out_ready = ($urandom_range(0, 2) != 0);
        end else begin
          out_ready = 1'b1;
        end
        if (out_valid) begin
          if (q_out.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL out_unexpected: out_valid=1 lo=%h, required no output", out_lo);
          end else begin
            e = q_out[0];
            chk("out_lo", 128'(out_lo), 128'(e.lo));
            chk("out_mid", 128'(out_mid), 128'(e.mid));
            chk("out_hi", 128'(out_hi), 128'(e.hi));
            chk1("in_ready_busy", in_ready, 1'b0);
            if (!out_seen) begin
              out_seen = 1'b1;
              if (e.lat > 0) chk("latency", 128'(cyc - e.acc), 128'(e.lat));
            end
            if (out_ready) begin
              void'(q_out.pop_front());
              out_seen = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  // Directed scenarios followed by a randomized run
  initial begin : driver
    logic [127:0] t1, t2;
    pend_t        lp;
    int           zl;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk_reset_state();

    // Unit product with minimum latency 3 + 1 + 1
    do_op(104'd1, 104'd1, 5);
    wait_idle();
    // High halves only
    do_op(104'd1 << 52, 104'd1 << 52, 0);
    wait_idle();
    // Mixed halves
    do_op((104'd1 << 52) | 104'd1, 104'd1, 0);
    wait_idle();
    chk1("err_clean", err, 1'b0);

    // Sub-multiplier and output backpressure, next op queued behind
    mul_stall = 5;
    out_hold = 4;
    t1 = {$urandom, $urandom, $urandom, $urandom};
    t2 = {$urandom, $urandom, $urandom, $urandom};
    do_op(t1[103:0], t2[103:0], 0);
    t1 = {$urandom, $urandom, $urandom, $urandom};
    do_op(t1[103:0], t2[103:0], 0);
    wait_idle();

    // Wrong tag on the first result: data still used, err sticky
    corrupt_first = 1'b1;
    t1 = {$urandom, $urandom, $urandom, $urandom};
    do_op(t1[103:0], t2[103:0], 0);
    wait_idle();
    repeat (2) @(negedge clk);
    chk1("err_set", err, 1'b1);
    t2 = {$urandom, $urandom, $urandom, $urandom};
    do_op(t1[103:0], t2[103:0], 0);
    wait_idle();
    repeat (2) @(negedge clk);
    chk1("err_sticky", err, 1'b1);

    // Reset in the middle of RUN, then late result pulses
    mul_stall = 20;
    do_op(t2[103:0], t1[103:0], 0);
    repeat (3) @(negedge clk);
    do_reset();
    @(negedge clk);
    chk_reset_state();
    @(posedge clk); #2;
    for (int i = 0; i < 3; i++) begin
      lp.d = {$urandom, $urandom, $urandom, $urandom};
      lp.tag = 2'($urandom_range(0, 3));
      lp.due = 0;
      q_res.push_back(lp);
    end
    repeat (6) @(negedge clk);
    chk1("late_out_valid", out_valid, 1'b0);
    chk1("late_err", err, 1'b0);
    chk1("late_in_ready", in_ready, 1'b1);
    do_op(t1[103:0], t2[103:0], 0);
    wait_idle();

    // Zero operand
    zl = 0;
`ifdef KS_ZERO_BYPASS_EN
    zl = 2;
`endif
    do_op(104'd0, 104'h5A, zl);
    wait_idle();

    // Randomized traffic
    rand_ready = 1'b1;
    rand_lat   = 1'b1;
    rand_out   = 1'b1;
    for (int k = 0; k < 40; k++) begin
      t1 = {$urandom, $urandom, $urandom, $urandom};
      t2 = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) t1[103:52] = '0;
      if ($urandom_range(0, 7) == 0) t2[51:0] = '0;
      do_op(t1[103:0], t2[103:0], 0);
    end
    wait_idle();
    repeat (5) @(negedge clk);
    chk1("err_final", err, 1'b0);
    chk("leftover_out", 128'(q_out.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
